pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl_pkg.sv | 27 ++
 rtl/pong_game_ctrl_if.sv | 40 ++++
 rtl/pong_game_ctrl_frame_timer.sv | 30 +++
 rtl/pong_game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the Pong game-flow controller.
package pong_pkg;

  // Game-flow states; codes 5-7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Default game tuning.
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 120;

  // Ball launch directions.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Larger of two integers, used to size the shared frame timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game controller and the VGA / ball datapath.
interface pong_game_ctrl_if
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = DEF_WIN_SCORE
);
  localparam int SW = $clog2(WIN_SCORE + 1);

  // Events from the datapath and player buttons.
  logic          frame_tick;
  logic          start;
  logic          pause;
  logic          miss_left;
  logic          miss_right;

  // Game-flow decisions back to the datapath and renderer.
  logic          ball_rst;
  logic          ball_move;
  logic          serve_dir;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          game_over;
  logic          winner;
  logic [2:0]    state_o;

  // Datapath side: produces events, consumes decisions.
  modport master (
    output frame_tick, start, pause, miss_left, miss_right,
    input  ball_rst, ball_move, serve_dir, score_l, score_r,
           game_over, winner, state_o
  );

  // Controller side.
  modport slave (
    input  frame_tick, start, pause, miss_left, miss_right,
    output ball_rst, ball_move, serve_dir, score_l, score_r,
           game_over, winner, state_o
  );

endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// Loadable frame down-counter; expire pulses on the tick that takes it 1 -> 0.
module frame_timer
  import pong_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         frame_tick,
  output logic         expire
);

  logic [W-1:0] count_reg;

  // Load has priority; otherwise count frame ticks down to zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (frame_tick && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expire = frame_tick && (count_reg == W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve / play / point / game-over control and scoring.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
  input  logic          clk,
  input  logic          rst,
  pong_game_ctrl_if.slave bus
);

  localparam int SW = $clog2(WIN_SCORE + 1);
  localparam int TW = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);

  localparam logic [SW-1:0] WIN_VAL    = SW'(WIN_SCORE);
  localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_FRAMES);
  localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_FRAMES);

  state_t        state_reg;
  logic          start_d_reg;
  logic          pause_d_reg;
  logic          paused_reg;
  logic          ball_rst_reg;
  logic          ball_move_reg;
  logic          serve_dir_reg;
  logic [SW-1:0] score_l_reg;
  logic [SW-1:0] score_r_reg;
  logic          game_over_reg;
  logic          winner_reg;

  logic          start_edge;
  logic          pause_edge;
  logic          miss_ok;
  logic          miss_both;
  logic          miss_l_only;
  logic          miss_r_only;
  logic [SW-1:0] score_l_next;
  logic [SW-1:0] score_r_next;
  logic          win_l;
  logic          win_r;
  logic          timer_tick;
  logic          timer_load;
  logic [TW-1:0] timer_load_val;
  logic          timer_expire;

  assign start_edge = bus.start && !start_d_reg;
  assign pause_edge = bus.pause && !pause_d_reg;

  // Misses only count during unpaused play.
  assign miss_ok     = (state_reg == PLAY) && !paused_reg;
  assign miss_both   = miss_ok && bus.miss_left && bus.miss_right;
  assign miss_l_only = miss_ok && bus.miss_left && !bus.miss_right;
  assign miss_r_only = miss_ok && bus.miss_right && !bus.miss_left;

  // Saturating score increments; a score can never pass WIN_SCORE.
  assign score_l_next = (score_l_reg < WIN_VAL) ? score_l_reg + SW'(1) : score_l_reg;
  assign score_r_next = (score_r_reg < WIN_VAL) ? score_r_reg + SW'(1) : score_r_reg;
  assign win_l        = (score_l_next == WIN_VAL);
  assign win_r        = (score_r_next == WIN_VAL);

  // The countdown only runs while serving or frozen after a point.
  assign timer_tick = bus.frame_tick && ((state_reg == SERVE) || (state_reg == POINT));

  // Reload the shared timer on every transition into SERVE or POINT.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = SERVE_LOAD;
    case (state_reg)
      IDLE, OVER: timer_load = start_edge;
      PLAY: begin
        if (miss_both) begin
          timer_load = 1'b1;
        end else if ((miss_l_only && !win_r) || (miss_r_only && !win_l)) begin
          timer_load     = 1'b1;
          timer_load_val = POINT_LOAD;
        end
      end
      POINT:   timer_load = timer_expire;
      default: timer_load = 1'b0;
    endcase
  end

  frame_timer #(
    .W (TW)
  ) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_val   (timer_load_val),
    .frame_tick (timer_tick),
    .expire     (timer_expire)
  );

  // Game-flow FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      start_d_reg   <= 1'b0;
      pause_d_reg   <= 1'b0;
      paused_reg    <= 1'b0;
      ball_rst_reg  <= 1'b1;
      ball_move_reg <= 1'b0;
      serve_dir_reg <= DIR_LEFT;
      score_l_reg   <= '0;
      score_r_reg   <= '0;
      game_over_reg <= 1'b0;
      winner_reg    <= 1'b0;
    end else begin
      start_d_reg   <= bus.start;
      pause_d_reg   <= bus.pause;
      ball_move_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ball_rst_reg <= 1'b1;
          if (start_edge) begin
            score_l_reg <= '0;
            score_r_reg <= '0;
            state_reg   <= SERVE;
          end
        end
        SERVE: begin
          ball_rst_reg <= 1'b1;
          if (timer_expire) begin
            state_reg    <= PLAY;
            ball_rst_reg <= 1'b0;
          end
        end
        PLAY: begin
          ball_rst_reg <= 1'b0;
          if (pause_edge) begin
            paused_reg <= !paused_reg;
          end
          if (miss_both) begin
            // Simultaneous misses: nobody scores, re-serve the other way.
            serve_dir_reg <= !serve_dir_reg;
            ball_rst_reg  <= 1'b1;
            state_reg     <= SERVE;
          end else if (miss_l_only) begin
            score_r_reg   <= score_r_next;
            serve_dir_reg <= DIR_LEFT;
            if (win_r) begin
              winner_reg    <= 1'b1;
              game_over_reg <= 1'b1;
              ball_rst_reg  <= 1'b1;
              state_reg     <= OVER;
            end else begin
              state_reg <= POINT;
            end
          end else if (miss_r_only) begin
            score_l_reg   <= score_l_next;
            serve_dir_reg <= DIR_RIGHT;
            if (win_l) begin
              winner_reg    <= 1'b0;
              game_over_reg <= 1'b1;
              ball_rst_reg  <= 1'b1;
              state_reg     <= OVER;
            end else begin
              state_reg <= POINT;
            end
          end else if (bus.frame_tick && !paused_reg) begin
            ball_move_reg <= 1'b1;
          end
        end
        POINT: begin
          ball_rst_reg <= 1'b0;
          if (timer_expire) begin
            paused_reg   <= 1'b0;
            ball_rst_reg <= 1'b1;
            state_reg    <= SERVE;
          end
        end
        OVER: begin
          game_over_reg <= 1'b1;
          ball_rst_reg  <= 1'b1;
          if (start_edge) begin
            score_l_reg   <= '0;
            score_r_reg   <= '0;
            game_over_reg <= 1'b0;
            paused_reg    <= 1'b0;
            state_reg     <= SERVE;
          end
        end
        default: begin
          game_over_reg <= 1'b0;
          paused_reg    <= 1'b0;
          ball_rst_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ball_rst  = ball_rst_reg;
  assign bus.ball_move = ball_move_reg;
  assign bus.serve_dir = serve_dir_reg;
  assign bus.score_l   = score_l_reg;
  assign bus.score_r   = score_r_reg;
  assign bus.game_over = game_over_reg;
  assign bus.winner    = winner_reg;
  assign bus.state_o   = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl with a small reference model of the game flow.
module tb_pong_game_ctrl;

  localparam int W  = 3;
  localparam int SF = 3;
  localparam int PF = 2;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_POINT = 3;
  localparam int S_OVER  = 4;

  typedef struct {
    int state;
    int brst;
    int move;
    int dir;
    int sl;
    int sr;
    int go;
    int win;
  } exp_t;

  logic clk;
  logic rst;

  pong_game_ctrl_if #(.WIN_SCORE(W)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE    (W),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   fail_cnt = 0;
  int   move_cnt = 0;
  bit   st_lvl   = 1'b0;
  bit   pz_lvl   = 1'b0;

  // Reference model state.
  int m_state, m_timer, m_sl, m_sr;
  bit m_paused, m_sd, m_pd, m_dir, m_win, m_move;

  task automatic check_eq(input string tag, input int got, input int want);
    chk_cnt++;
    if (got != want) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Advance the model by one clock and queue what the DUT should show after it.
  task automatic model_step(input bit r, input bit ft, input bit st, input bit pz,
                            input bit ml, input bit mr);
    bit   se, pe;
    exp_t e;
    if (r) begin
      m_state = S_IDLE; m_timer = 0; m_sl = 0; m_sr = 0;
      m_paused = 0; m_sd = 0; m_pd = 0; m_dir = 0; m_win = 0; m_move = 0;
    end else begin
      se = st && !m_sd;
      pe = pz && !m_pd;
      m_sd = st;
      m_pd = pz;
      m_move = 0;
      case (m_state)
        S_IDLE, S_OVER: begin
          if (se) begin
            m_sl = 0; m_sr = 0; m_paused = 0; m_timer = SF; m_state = S_SERVE;
          end
        end
        S_SERVE: begin
          if (ft) begin
            m_timer--;
            if (m_timer == 0) m_state = S_PLAY;
          end
        end
        S_PLAY: begin
          if (!m_paused) begin
            if (ml && mr) begin
              m_dir = !m_dir; m_timer = SF; m_state = S_SERVE;
            end else if (ml) begin
              if (m_sr < W) m_sr++;
              m_dir = 0;
              if (m_sr == W) begin m_state = S_OVER; m_win = 1; end
              else begin m_state = S_POINT; m_timer = PF; end
            end else if (mr) begin
              if (m_sl < W) m_sl++;
              m_dir = 1;
              if (m_sl == W) begin m_state = S_OVER; m_win = 0; end
              else begin m_state = S_POINT; m_timer = PF; end
            end else if (ft) begin
              m_move = 1;
            end
          end
          if (pe) m_paused = !m_paused;
        end
        S_POINT: begin
          if (ft) begin
            m_timer--;
            if (m_timer == 0) begin m_state = S_SERVE; m_timer = SF; m_paused = 0; end
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
    e.state = m_state;
    e.brst  = (m_state == S_IDLE || m_state == S_SERVE || m_state == S_OVER) ? 1 : 0;
    e.move  = m_move;
    e.dir   = m_dir;
    e.sl    = m_sl;
    e.sr    = m_sr;
    e.go    = (m_state == S_OVER) ? 1 : 0;
    e.win   = m_win;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; the expectation is popped once the DUT has updated.
  task automatic tick(input bit r, input bit ft, input bit ml, input bit mr);
    exp_t e;
    rst            = r;
    bus.frame_tick = ft;
    bus.start      = st_lvl;
    bus.pause      = pz_lvl;
    bus.miss_left  = ml;
    bus.miss_right = mr;
    model_step(r, ft, st_lvl, pz_lvl, ml, mr);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("state",     bus.state_o,   e.state);
    check_eq("ball_rst",  bus.ball_rst,  e.brst);
    check_eq("ball_move", bus.ball_move, e.move);
    check_eq("serve_dir", bus.serve_dir, e.dir);
    check_eq("score_l",   bus.score_l,   e.sl);
    check_eq("score_r",   bus.score_r,   e.sr);
    check_eq("game_over", bus.game_over, e.go);
    check_eq("winner",    bus.winner,    e.win);
    if (bus.ball_move) move_cnt++;
    $display("t=%0t rst=%0b ft=%0b st=%0b pz=%0b ml=%0b mr=%0b -> st=%0d sl=%0d sr=%0d mv=%0b go=%0b",
             $time, r, ft, st_lvl, pz_lvl, ml, mr, bus.state_o, bus.score_l, bus.score_r,
             bus.ball_move, bus.game_over);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 1, 0, 0);
      idle(2);
    end
  endtask

  task automatic pulse_start();
    st_lvl = 1'b1; tick(0, 0, 0, 0);
    st_lvl = 1'b0; tick(0, 0, 0, 0);
  endtask

  task automatic pulse_pause();
    pz_lvl = 1'b1; tick(0, 0, 0, 0);
    pz_lvl = 1'b0; tick(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_tick = 0; bus.start = 0; bus.pause = 0;
    bus.miss_left = 0; bus.miss_right = 0;

    // Reset state.
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_eq("rst_state", bus.state_o, S_IDLE);
    check_eq("rst_ball_rst", bus.ball_rst, 1);
    check_eq("rst_score_l", bus.score_l, 0);
    idle(2);

    // Start, serve countdown, play.
    pulse_start();
    check_eq("start_state", bus.state_o, S_SERVE);
    check_eq("start_ball_rst", bus.ball_rst, 1);
    frames(SF - 1);
    check_eq("serve_hold", bus.state_o, S_SERVE);
    frames(1);
    check_eq("serve_done", bus.state_o, S_PLAY);
    check_eq("play_ball_rst", bus.ball_rst, 0);
    move_cnt = 0;
    frames(3);
    check_eq("play_moves", move_cnt, 3);

    // miss_right together with a frame tick: point for left, no move.
    tick(0, 1, 0, 1);
    check_eq("mr_score_l", bus.score_l, 1);
    check_eq("mr_dir", bus.serve_dir, 1);
    check_eq("mr_state", bus.state_o, S_POINT);
    check_eq("mr_no_move", bus.ball_move, 0);
    frames(PF);
    check_eq("point_done", bus.state_o, S_SERVE);
    frames(SF);
    check_eq("reserve_done", bus.state_o, S_PLAY);

    // Right player wins with start held high the whole time.
    st_lvl = 1'b1;
    for (int k = 0; k < W; k++) begin
      tick(0, 0, 1, 0);
      if (k < W - 1) begin
        check_eq("ml_point", bus.state_o, S_POINT);
        frames(PF);
        frames(SF);
      end
    end
    check_eq("win_score_r", bus.score_r, W);
    check_eq("win_state", bus.state_o, S_OVER);
    check_eq("win_game_over", bus.game_over, 1);
    check_eq("win_winner", bus.winner, 1);
    tick(0, 0, 1, 0);
    check_eq("over_sat", bus.score_r, W);
    idle(4);
    check_eq("held_start", bus.state_o, S_OVER);
    st_lvl = 1'b0;
    tick(0, 0, 0, 0);
    pulse_start();
    check_eq("restart_state", bus.state_o, S_SERVE);
    check_eq("restart_score_r", bus.score_r, 0);
    check_eq("restart_go", bus.game_over, 0);

    // Simultaneous misses.
    frames(SF);
    tick(0, 0, 1, 1);
    check_eq("both_sl", bus.score_l, 0);
    check_eq("both_sr", bus.score_r, 0);
    check_eq("both_dir", bus.serve_dir, 1);
    check_eq("both_state", bus.state_o, S_SERVE);
    frames(SF);

    // Pause freezes movement and ignores misses.
    pulse_pause();
    move_cnt = 0;
    frames(5);
    check_eq("paused_moves", move_cnt, 0);
    tick(0, 0, 1, 0);
    check_eq("paused_miss", bus.score_r, 0);
    check_eq("paused_state", bus.state_o, S_PLAY);
    pulse_pause();
    move_cnt = 0;
    frames(2);
    check_eq("resume_moves", move_cnt, 2);

    // Reset mid-countdown in POINT.
    tick(0, 0, 0, 1);
    check_eq("pt_state", bus.state_o, S_POINT);
    frames(1);
    tick(1, 0, 0, 0);
    check_eq("rst_pt_state", bus.state_o, S_IDLE);
    check_eq("rst_pt_sl", bus.score_l, 0);
    check_eq("rst_pt_ball_rst", bus.ball_rst, 1);
    check_eq("rst_pt_go", bus.game_over, 0);

    // Left player wins, then restart from OVER.
    pulse_start();
    frames(SF);
    for (int k = 0; k < W; k++) begin
      tick(0, 0, 0, 1);
      if (k < W - 1) begin
        frames(PF);
        frames(SF);
      end
    end
    check_eq("lwin_state", bus.state_o, S_OVER);
    check_eq("lwin_winner", bus.winner, 0);
    check_eq("lwin_score_l", bus.score_l, W);
    pulse_start();
    check_eq("lrestart_state", bus.state_o, S_SERVE);
    check_eq("lrestart_sl", bus.score_l, 0);

    // Reset while paused clears the pause.
    frames(SF);
    pulse_pause();
    tick(1, 0, 0, 0);
    check_eq("rst_pause_state", bus.state_o, S_IDLE);
    pulse_start();
    frames(SF);
    move_cnt = 0;
    frames(1);
    check_eq("rst_pause_cleared", move_cnt, 1);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
